// File: rtl/sloth_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sloth_mem_pkg
// Description : Shared types and constants for the memory-stage SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package sloth_mem_pkg;

    localparam int          WORD_WIDTH        = 32;
    localparam int          SRAM_DATA_WIDTH   = 16;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    // Access sequencing: a word access is a LOW halfword phase followed by a HIGH one
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage : sloth_mem_pkg
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder
// Description : Services 32-bit memory-stage reads/writes against a 16-bit
//               asynchronous SRAM as two halfword phases with wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_responder
    import sloth_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
    parameter int          ACCESS_CYCLES   = 2,
    parameter int          SRAM_ADDR_WIDTH = 18
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mem_read,
    input  logic                          mem_write,
    input  logic [WORD_WIDTH-1:0]         address,
    input  logic [WORD_WIDTH-1:0]         write_data,
    output logic [WORD_WIDTH-1:0]         read_data,
    output logic                          ready,
    output logic [SRAM_ADDR_WIDTH-1:0]    sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0]    sram_dq_out,
    input  logic [SRAM_DATA_WIDTH-1:0]    sram_dq_in,
    output logic                          sram_dq_oe,
    output logic                          sram_we_n
);

    // Counter only needs to reach ACCESS_CYCLES-1
    localparam int               CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]   read_data_q, read_data_d;

    logic                    w_req;
    logic                    w_last;
    logic                    w_in_phase;
    logic                    w_half;
    logic                    w_is_read;
    logic [WORD_WIDTH-1:0]   w_offset;
    logic                    w_unused_offset;

    assign w_req      = mem_read | mem_write;
    assign w_last     = (cnt_q == CNT_LAST);
    assign w_in_phase = (state_q == LOW) || (state_q == HIGH);
    assign w_half     = (state_q == HIGH);
    // Simultaneous read and write is serviced as a write only
    assign w_is_read  = mem_read & ~mem_write;

    // Offset wraps modulo 2^32; bits above the SRAM size are discarded
    assign w_offset        = address - BASE_ADDR;
    assign w_unused_offset = ^{w_offset[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], w_offset[1:0]};

    // State, phase counter and captured read word
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
        end
    end

    // Next-state and phase-counter sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_req) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            end
            LOW: begin
                if (w_last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (w_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Pipeline advances on this edge; any request next cycle is new
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Read capture: sample SRAM data on the last clock of each read phase
    always_comb begin
        read_data_d = read_data_q;
        if (w_in_phase && w_is_read && w_last) begin
            if (w_half) begin
                read_data_d = {sram_dq_in, read_data_q[15:0]};
            end else begin
                read_data_d = {read_data_q[31:16], sram_dq_in};
            end
        end
    end

    // SRAM pin drive, derived directly from the current phase
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (w_in_phase) begin
            sram_addr = {w_offset[SRAM_ADDR_WIDTH:2], w_half};
            if (mem_write) begin
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = w_half ? write_data[31:16] : write_data[15:0];
            end
        end
    end

    assign ready     = ~w_req | (state_q == DONE);
    assign read_data = read_data_q;

endmodule : sram_responder
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_responder
// Description : Directed self-checking bench for sram_responder with
//               ACCESS_CYCLES=2 (instance a) and ACCESS_CYCLES=1 (instance b).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_responder;

    logic        clk;
    logic        rst;

    logic        mem_read_a, mem_write_a, ready_a, oe_a, we_n_a;
    logic [31:0] address_a, write_data_a, read_data_a;
    logic [17:0] sram_addr_a;
    logic [15:0] dq_out_a, dq_in_a;

    logic        mem_read_b, mem_write_b, ready_b, oe_b, we_n_b;
    logic [31:0] address_b, write_data_b, read_data_b;
    logic [17:0] sram_addr_b;
    logic [15:0] dq_out_b, dq_in_b;

    logic [15:0] mem [0:7];

    int checks = 0;
    int errors = 0;

    // Asynchronous SRAM model: data follows the address combinationally
    assign dq_in_a = mem[sram_addr_a[2:0]];
    assign dq_in_b = mem[sram_addr_b[2:0]];

    sram_responder #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(2), .SRAM_ADDR_WIDTH(18)) dut_a (
        .clk(clk), .rst(rst),
        .mem_read(mem_read_a), .mem_write(mem_write_a),
        .address(address_a), .write_data(write_data_a),
        .read_data(read_data_a), .ready(ready_a),
        .sram_addr(sram_addr_a), .sram_dq_out(dq_out_a), .sram_dq_in(dq_in_a),
        .sram_dq_oe(oe_a), .sram_we_n(we_n_a)
    );

    sram_responder #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(1), .SRAM_ADDR_WIDTH(18)) dut_b (
        .clk(clk), .rst(rst),
        .mem_read(mem_read_b), .mem_write(mem_write_b),
        .address(address_b), .write_data(write_data_b),
        .read_data(read_data_b), .ready(ready_b),
        .sram_addr(sram_addr_b), .sram_dq_out(dq_out_b), .sram_dq_in(dq_in_b),
        .sram_dq_oe(oe_b), .sram_we_n(we_n_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check all SRAM pins of instance a in one go
    task automatic pins_a(input string tag, input logic rdy, input logic wen, input logic oe,
                          input logic [17:0] addr, input logic [15:0] dq);
        chk({tag, "_ready"}, {31'd0, ready_a}, {31'd0, rdy});
        chk({tag, "_we_n"},  {31'd0, we_n_a},  {31'd0, wen});
        chk({tag, "_oe"},    {31'd0, oe_a},    {31'd0, oe});
        chk({tag, "_addr"},  {14'd0, sram_addr_a}, {14'd0, addr});
        chk({tag, "_dq"},    {16'd0, dq_out_a}, {16'd0, dq});
    endtask

    initial begin
        mem[0] = 16'hBEEF; mem[1] = 16'hDEAD; mem[2] = 16'h1234; mem[3] = 16'h5678;
        mem[4] = 16'h0; mem[5] = 16'h0; mem[6] = 16'h0; mem[7] = 16'h0;
        rst = 1'b0;
        mem_read_a = 0; mem_write_a = 0; address_a = 32'd0; write_data_a = 32'd0;
        mem_read_b = 0; mem_write_b = 0; address_b = 32'd0; write_data_b = 32'd0;
        step(); step();
        rst = 1'b1;
        step();

        // Reset state
        pins_a("reset", 1'b1, 1'b1, 1'b0, 18'd0, 16'd0);
        chk("reset_rdata", read_data_a, 32'd0);

        // Write 0xDEADBEEF to 1024: cycle 0 IDLE, 1-2 LOW, 3-4 HIGH, 5 DONE
        mem_write_a = 1; address_a = 32'd1024; write_data_a = 32'hDEADBEEF;
        #1;
        pins_a("wr_c0", 1'b0, 1'b1, 1'b0, 18'd0, 16'd0);
        step(); pins_a("wr_c1", 1'b0, 1'b0, 1'b1, 18'd0, 16'hBEEF);
        step(); pins_a("wr_c2", 1'b0, 1'b0, 1'b1, 18'd0, 16'hBEEF);
        step(); pins_a("wr_c3", 1'b0, 1'b0, 1'b1, 18'd1, 16'hDEAD);
        step(); pins_a("wr_c4", 1'b0, 1'b0, 1'b1, 18'd1, 16'hDEAD);
        step(); pins_a("wr_c5", 1'b1, 1'b1, 1'b0, 18'd0, 16'd0);

        // Back-to-back read presented right after DONE; write must not repeat
        step();
        mem_write_a = 0; mem_read_a = 1; address_a = 32'd1024;
        #1;
        pins_a("rd_c0", 1'b0, 1'b1, 1'b0, 18'd0, 16'd0);
        step(); pins_a("rd_c1", 1'b0, 1'b1, 1'b0, 18'd0, 16'd0);
        step(); pins_a("rd_c2", 1'b0, 1'b1, 1'b0, 18'd0, 16'd0);
        step(); pins_a("rd_c3", 1'b0, 1'b1, 1'b0, 18'd1, 16'd0);
        step(); pins_a("rd_c4", 1'b0, 1'b1, 1'b0, 18'd1, 16'd0);
        step();
        chk("rd_c5_ready", {31'd0, ready_a}, 32'd1);
        chk("rd_c5_rdata", read_data_a, 32'hDEADBEEF);
        step();
        mem_read_a = 0;
        #1;
        chk("rd_hold_rdata", read_data_a, 32'hDEADBEEF);
        chk("rd_hold_ready", {31'd0, ready_a}, 32'd1);

        // Read at 1028 maps to halfwords 2 then 3
        step();
        mem_read_a = 1; address_a = 32'd1028;
        step(); chk("a1028_c1_addr", {14'd0, sram_addr_a}, 32'd2);
        step(); step(); chk("a1028_c3_addr", {14'd0, sram_addr_a}, 32'd3);
        step(); step();
        chk("a1028_ready", {31'd0, ready_a}, 32'd1);
        chk("a1028_rdata", read_data_a, 32'h56781234);
        step();
        mem_read_a = 0;

        // Write at 1024+2^20 wraps to halfwords 0 then 1
        step();
        mem_write_a = 1; address_a = 32'd1024 + 32'h0010_0000; write_data_a = 32'h0BADF00D;
        step(); pins_a("wrap_c1", 1'b0, 1'b0, 1'b1, 18'd0, 16'hF00D);
        step(); step(); pins_a("wrap_c3", 1'b0, 1'b0, 1'b1, 18'd1, 16'h0BAD);
        step(); step();
        chk("wrap_ready", {31'd0, ready_a}, 32'd1);
        step();
        mem_write_a = 0;

        // Reset asserted during HIGH of a write aborts it
        step();
        mem_write_a = 1; address_a = 32'd1028; write_data_a = 32'hCAFEF00D;
        step(); step(); step();
        pins_a("abort_high", 1'b0, 1'b0, 1'b1, 18'd3, 16'hCAFE);
        rst = 1'b0;
        step();
        pins_a("abort_idle", 1'b0, 1'b1, 1'b0, 18'd0, 16'd0);
        chk("abort_rdata", read_data_a, 32'd0);
        rst = 1'b1;
        step(); pins_a("restart_c1", 1'b0, 1'b0, 1'b1, 18'd2, 16'hF00D);
        step(); step(); pins_a("restart_c3", 1'b0, 1'b0, 1'b1, 18'd3, 16'hCAFE);
        step(); step();
        chk("restart_ready", {31'd0, ready_a}, 32'd1);
        step();
        mem_write_a = 0;

        // ACCESS_CYCLES=1: read first so read_data is known non-zero
        step();
        mem_read_b = 1; address_b = 32'd1024;
        step(); step(); step();
        chk("b_rd_ready", {31'd0, ready_b}, 32'd1);
        chk("b_rd_rdata", read_data_b, 32'hDEADBEEF);
        step();
        // Read and write together: write waveform, read_data unchanged
        mem_read_b = 1; mem_write_b = 1; address_b = 32'd1028; write_data_b = 32'h11112222;
        #1;
        chk("b_both_c0_ready", {31'd0, ready_b}, 32'd0);
        step();
        chk("b_both_c1_we_n", {31'd0, we_n_b}, 32'd0);
        chk("b_both_c1_oe",   {31'd0, oe_b},   32'd1);
        chk("b_both_c1_addr", {14'd0, sram_addr_b}, 32'd2);
        chk("b_both_c1_dq",   {16'd0, dq_out_b}, 32'h2222);
        chk("b_both_c1_ready", {31'd0, ready_b}, 32'd0);
        step();
        chk("b_both_c2_addr", {14'd0, sram_addr_b}, 32'd3);
        chk("b_both_c2_dq",   {16'd0, dq_out_b}, 32'h1111);
        chk("b_both_c2_ready", {31'd0, ready_b}, 32'd0);
        step();
        chk("b_both_c3_ready", {31'd0, ready_b}, 32'd1);
        chk("b_both_c3_we_n",  {31'd0, we_n_b},  32'd1);
        chk("b_both_rdata", read_data_b, 32'hDEADBEEF);
        step();
        mem_read_b = 0; mem_write_b = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sram_responder
`default_nettype wire
